// File: rtl/master_axi_write_sequencer.sv
// AXI4 write-transaction sequencer: drives AW and W concurrently, then waits on B,
// with an optional abort after TIMEOUT_CYCLES busy cycles.
module master_axi_write_sequencer #(
    parameter int BRESP_WIDTH    = 2,
    parameter int TIMEOUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [BRESP_WIDTH-1:0] response,
    output logic                   error,
    output logic                   timeout,
    output logic                   aw_enable,
    input  logic                   aw_done,
    output logic                   w_enable,
    input  logic                   w_done,
    output logic                   b_enable,
    input  logic                   b_done,
    input  logic [BRESP_WIDTH-1:0] b_response
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_DATA = 2'd1,
        RESP      = 2'd2
    } state_t;

    localparam bit                     TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   r_state;
    logic                     r_aw_got;
    logic                     r_w_got;
    logic [TIMEOUT_WIDTH-1:0] r_count;
    logic                     r_done;
    logic [BRESP_WIDTH-1:0]   r_response;
    logic                     r_error;
    logic                     r_timeout;

    logic w_aw_hit;
    logic w_w_hit;
    logic w_expired;

    // Enables depend only on registered state so no path runs from *_done back to *_enable.
    assign aw_enable = (r_state == ADDR_DATA) && !r_aw_got;
    assign w_enable  = (r_state == ADDR_DATA) && !r_w_got;
    assign b_enable  = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign response  = r_response;
    assign error     = r_error;
    assign timeout   = r_timeout;

    assign w_aw_hit  = r_aw_got || (aw_enable && aw_done);
    assign w_w_hit   = r_w_got  || (w_enable  && w_done);
    assign w_expired = TIMEOUT_EN && (r_count == TIMEOUT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_response <= '0;
            r_error    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= ADDR_DATA;
                        r_aw_got   <= 1'b0;
                        r_w_got    <= 1'b0;
                        r_count    <= '0;
                        r_response <= '0;
                        r_error    <= 1'b0;
                        r_timeout  <= 1'b0;
                    end
                end
                ADDR_DATA: begin
                    r_count <= r_count + TIMEOUT_WIDTH'(1);
                    if (w_expired) begin
                        r_state   <= IDLE;
                        r_aw_got  <= 1'b0;
                        r_w_got   <= 1'b0;
                        r_timeout <= 1'b1;
                        r_error   <= 1'b1;
                        r_done    <= 1'b1;
                    end else if (w_aw_hit && w_w_hit) begin
                        r_state  <= RESP;
                        r_aw_got <= 1'b0;
                        r_w_got  <= 1'b0;
                    end else begin
                        r_aw_got <= w_aw_hit;
                        r_w_got  <= w_w_hit;
                    end
                end
                RESP: begin
                    r_count <= r_count + TIMEOUT_WIDTH'(1);
                    // A response arriving in the expiry cycle still counts as completion.
                    if (b_done) begin
                        r_state    <= IDLE;
                        r_response <= b_response;
                        r_error    <= (b_response != '0);
                        r_done     <= 1'b1;
                    end else if (w_expired) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                        r_error   <= 1'b1;
                        r_done    <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
